// File: rtl/fnd_scan_pkg.sv
// Shared constants, types and helpers for the 4-digit FND scan controller.
package fnd_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MASK_W     = NUM_DIGITS;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  // Common-anode digit lines and decimal point are active-low.
  localparam logic [MASK_W-1:0] COM_OFF = 4'b1111;
  localparam logic              DP_OFF  = 1'b1;

  typedef logic [1:0] idx_t;

  // One buffered display image: four nibbles plus per-digit decimal points.
  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [MASK_W-1:0]  dp;
  } frame_buf_t;

  // True when every nibble from position i up to the leftmost digit is zero.
  function automatic logic lead_zero(input logic [VALUE_W-1:0] v, input idx_t i);
    logic [VALUE_W-1:0] shifted;
    shifted = v >> {i, 2'b00};
    return shifted == '0;
  endfunction

endpackage

// File: rtl/fnd_scan_tick.sv
// Slot prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each slot.
module fnd_scan_tick #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  // Free-running slot counter, wraps to zero on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan.sv
// Time-multiplexed 4-digit FND scan controller with frame-synchronous double buffering.
module fnd_scan
  import fnd_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  input  logic [MASK_W-1:0]   dp_in,
  output logic [NIBBLE_W-1:0] digit_val,
  output logic                blank,
  output logic                dp,
  output logic [MASK_W-1:0]   com,
  output logic                frame_done
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt;
  logic            tick;
  logic            wrap;
  idx_t            idx_q;
  frame_buf_t      shadow_q;
  frame_buf_t      disp_q;
  logic            pending_q;

  fnd_scan_tick #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CntW)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  assign wrap = tick && (idx_q == idx_t'(NUM_DIGITS - 1));

  // Digit index advances once per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (tick) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Double buffer: load fills shadow; disp only changes on a frame wrap.
  // A load on the wrap cycle keeps pending set so it lands on the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        disp_q <= shadow_q;
      end
      if (load) begin
        shadow_q  <= '{value: value, dp: dp_in};
        pending_q <= 1'b1;
      end else if (wrap) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Registered outputs, one clock behind the (idx, cnt) state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_val  <= '0;
      blank      <= 1'b1;
      dp         <= DP_OFF;
      com        <= COM_OFF;
      frame_done <= 1'b0;
    end else begin
      digit_val  <= disp_q.value[idx_q*NIBBLE_W +: NIBBLE_W];
      dp         <= ~disp_q.dp[idx_q];
      // All digits off in the first cycle of each slot to avoid ghosting.
      com        <= (cnt == '0) ? COM_OFF : ~(MASK_W'(1) << idx_q);
      blank      <= BLANK_LZ && (idx_q != '0) && lead_zero(disp_q.value, idx_q);
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_fnd_scan.sv
// Directed scoreboard bench for fnd_scan with CLK_DIV = 4, both leading-zero modes.
module tb_fnd_scan;

  localparam int unsigned Div = 4;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpr;
    logic [3:0]  lz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [3:0] dv1, com1, dv0, com0;
  logic       bl1, dp1, fd1, bl0, dp0, fd0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fnd_scan #(.CLK_DIV(Div), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .digit_val(dv1), .blank(bl1), .dp(dp1), .com(com1), .frame_done(fd1)
  );

  fnd_scan #(.CLK_DIV(Div), .BLANK_LZ(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .digit_val(dv0), .blank(bl0), .dp(dp0), .com(com0), .frame_done(fd0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " lz"}, {22'd0, com1, dv1, dp1, bl1}, {22'd0, 4'hF, 4'h0, 1'b1, 1'b1});
    chk({tag, " nz"}, {22'd0, com0, dv0, dp0, bl0}, {22'd0, 4'hF, 4'h0, 1'b1, 1'b1});
    chk({tag, " fd"}, {30'd0, fd1, fd0}, 32'd0);
  endtask

  // Called at the negedge just before a frame's first output cycle. Pops the
  // expected image and checks every cycle up to stop_j, driving up to two loads.
  task automatic run_frame(input string tag, input int stop_j,
                           input int l1_j, input logic [15:0] l1_v, input logic [3:0] l1_d,
                           input int l2_j, input logic [15:0] l2_v, input logic [3:0] l2_d);
    exp_t e;
    int s, ph;
    logic [3:0] ecom, edv;
    if (exp_q.size() == 0) begin
      chk({tag, " queue empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int j = 1; j <= stop_j; j++) begin
      @(negedge clk);
      s    = (j - 1) / 4;
      ph   = (j - 1) % 4;
      ecom = (ph == 0) ? 4'hF : ~(4'b0001 << s);
      edv  = e.val[s*4 +: 4];
      chk($sformatf("%s j=%0d lz", tag, j), {22'd0, com1, dv1, dp1, bl1},
          {22'd0, ecom, edv, ~e.dpr[s], e.lz[s]});
      chk($sformatf("%s j=%0d nz", tag, j), {22'd0, com0, dv0, dp0, bl0},
          {22'd0, ecom, edv, ~e.dpr[s], 1'b0});
      chk($sformatf("%s j=%0d fd", tag, j), {30'd0, fd1, fd0},
          (j == 16) ? 32'd3 : 32'd0);
      if (j == l1_j) begin
        load = 1'b1; value = l1_v; dp_in = l1_d;
      end else if (j == l2_j) begin
        load = 1'b1; value = l2_v; dp_in = l2_d;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Blank display; load 12AF mid-frame must not show until the wrap.
    exp_q.push_back('{val: 16'h0000, dpr: 4'b0000, lz: 4'b1110});
    exp_q.push_back('{val: 16'h12AF, dpr: 4'b0100, lz: 4'b0000});
    run_frame("f1_zero", 16, 5, 16'h12AF, 4'b0100, 0, 16'h0, 4'h0);

    // 12AF shown; load 0050 for leading-zero blanking.
    exp_q.push_back('{val: 16'h0050, dpr: 4'b0000, lz: 4'b1100});
    run_frame("f2_12af", 16, 3, 16'h0050, 4'b0000, 0, 16'h0, 4'h0);

    // Back-to-back loads within one frame: last wins.
    exp_q.push_back('{val: 16'h2222, dpr: 4'b0000, lz: 4'b0000});
    run_frame("f3_0050", 16, 6, 16'h1111, 4'b0000, 8, 16'h2222, 4'b0000);

    // Pending 3333, then 4444 arrives on the wrap cycle itself.
    exp_q.push_back('{val: 16'h3333, dpr: 4'b0001, lz: 4'b0000});
    exp_q.push_back('{val: 16'h4444, dpr: 4'b1000, lz: 4'b0000});
    run_frame("f4_2222", 16, 2, 16'h3333, 4'b0001, 15, 16'h4444, 4'b1000);
    run_frame("f5_3333", 16, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    // Leave 5555 pending, then reset mid slot 2 without a clock edge.
    run_frame("f6_4444", 10, 4, 16'h5555, 4'b1111, 0, 16'h0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    chk_reset("reset_held");
    rst = 1'b0;

    // Pending 5555 discarded: two frames of zero.
    exp_q.push_back('{val: 16'h0000, dpr: 4'b0000, lz: 4'b1110});
    exp_q.push_back('{val: 16'h0000, dpr: 4'b0000, lz: 4'b1110});
    run_frame("f7_post", 16, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    run_frame("f8_post", 16, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
